// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the I/D cache memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int WORD_BYTES     = 4;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BURST = 2'd1,
    D_BURST = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if #(parameter int LINE_WORDS = mem_arbiter_pkg::LINE_WORDS_DEF);
  localparam int IW = $clog2(LINE_WORDS);

  logic        ireq;
  logic [31:0] iaddr;
  logic        igrant;
  logic        ivalid;
  logic        idone;
  logic [31:0] idata;

  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        dgrant;
  logic        dvalid;
  logic        ddone;
  logic [31:0] drdata;

  logic [IW-1:0] widx;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Handshake: a cache holds its req until its done pulse; memory answers each
  // word of an active mem_req with a one-cycle mem_ack (mem_rdata valid with it).
  modport slave (
    input  ireq, iaddr, dreq, dwe, daddr, dwdata, mem_ack, mem_rdata,
    output igrant, ivalid, idone, idata, dgrant, dvalid, ddone, drdata,
           widx, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ireq, iaddr, dreq, dwe, daddr, dwdata, mem_ack, mem_rdata,
    input  igrant, ivalid, idone, idata, dgrant, dvalid, ddone, drdata,
           widx, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between I and D requests with a last-served register.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   take,
  output owner_t pick
);

  owner_t last_q;

  // On a tie the side not served last wins; reset leaves I as last so D wins first.
  always_comb begin
    pick = OWN_I;
    if (req_i && req_d) begin
      pick = (last_q == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      pick = OWN_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= OWN_I;
    end else if (take) begin
      last_q <= pick;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one burst memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output state_t        dbg_state
);

  localparam int CW = $clog2(LINE_WORDS);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   base_q;
  logic          we_q;
  owner_t        owner_q;
  logic [31:0]   idata_q;
  logic [31:0]   drdata_q;
  logic          ivalid_q;
  logic          dvalid_q;

  owner_t pick;
  logic   take;
  logic   in_burst;
  logic   ack_in;
  logic   last_word;

  assign take      = (state_q == IDLE) && (bus.ireq || bus.dreq);
  assign in_burst  = (state_q == I_BURST) || (state_q == D_BURST);
  assign ack_in    = in_burst && bus.mem_ack;
  assign last_word = (cnt_q == CW'(LINE_WORDS - 1));

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req_i (bus.ireq),
    .req_d (bus.dreq),
    .take  (take),
    .pick  (pick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = (pick == OWN_D) ? D_BURST : I_BURST;
      I_BURST,
      D_BURST: if (ack_in && last_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst context is captured on the grant edge; cnt wraps to 0 on the last ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      base_q   <= '0;
      we_q     <= 1'b0;
      owner_q  <= OWN_I;
      idata_q  <= '0;
      drdata_q <= '0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      ivalid_q <= ack_in && (state_q == I_BURST);
      dvalid_q <= ack_in && (state_q == D_BURST) && !we_q;
      if (take) begin
        base_q  <= (pick == OWN_D) ? bus.daddr : bus.iaddr;
        we_q    <= (pick == OWN_D) && bus.dwe;
        owner_q <= pick;
        cnt_q   <= '0;
      end else if (ack_in) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (ack_in && (state_q == I_BURST)) begin
        idata_q <= bus.mem_rdata;
      end
      if (ack_in && (state_q == D_BURST) && !we_q) begin
        drdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = in_burst;
  assign bus.igrant    = (state_q == I_BURST);
  assign bus.dgrant    = (state_q == D_BURST);
  assign bus.mem_addr  = in_burst ? (base_q + {{(30 - CW){1'b0}}, cnt_q, 2'b00}) : 32'd0;
  assign bus.mem_we    = (state_q == D_BURST) && we_q;
  assign bus.mem_wdata = bus.mem_we ? bus.dwdata : 32'd0;
  assign bus.widx      = cnt_q;
  assign bus.idone     = (state_q == DONE) && (owner_q == OWN_I);
  assign bus.ddone     = (state_q == DONE) && (owner_q == OWN_D);
  assign bus.ivalid    = ivalid_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.idata     = idata_q;
  assign bus.drdata    = drdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences, random traffic vs. a burst-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LW = 4;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  mem_arbiter_if #(.LINE_WORDS(LW)) bus();

  mem_arbiter #(.LINE_WORDS(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Burst-level reference: an active burst record, a pending done, pending valids.
  bit          m_busy, m_owner_d, m_we, m_done, m_last_d, m_iv, m_dv;
  int          m_words;
  logic [31:0] m_base, m_idata, m_drdata;
  int          seen_iv, seen_dv, seen_id, seen_dd;

  typedef struct {
    bit          i, d, ack;
    bit          e_req, e_ig, e_dg;
    logic [31:0] e_addr;
    bit          e_iv, e_dv, e_id, e_dd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  function automatic logic [31:0] wb_word(input logic [31:0] a);
    return ~a + 32'h0000_1357;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_base + 32'(m_words) * 32'd4;
  endfunction

  function automatic logic [31:0] rand_line();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FF00 | r[7:0];
    return r & ~32'(LW * 4 - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_we = 0; m_done = 0; m_last_d = 0;
    m_iv = 0; m_dv = 0; m_words = 0; m_base = '0; m_idata = '0; m_drdata = '0;
  endtask

  task automatic drive_idle();
    bus.ireq = 0; bus.dreq = 0; bus.dwe = 0; bus.iaddr = '0; bus.daddr = '0;
    bus.dwdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_mem_req"}, bus.mem_req, 1'b0);
    chk1({tag, "_igrant"}, bus.igrant, 1'b0);
    chk1({tag, "_dgrant"}, bus.dgrant, 1'b0);
    chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk1({tag, "_ivalid"}, bus.ivalid, 1'b0);
    chk1({tag, "_dvalid"}, bus.dvalid, 1'b0);
    chk1({tag, "_idone"}, bus.idone, 1'b0);
    chk1({tag, "_ddone"}, bus.ddone, 1'b0);
    chk({tag, "_widx"}, 32'(bus.widx), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1;
    drive_idle();
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  // One clock of traffic: drive, compare against the model, then advance the model.
  task automatic run_cycle(input bit i, input bit d, input bit we, input bit ack,
                           input logic [31:0] ia, input logic [31:0] da);
    bit          nv_i, nv_d;
    logic [31:0] nd, exp_wd;
    @(negedge clk);
    bus.ireq = i; bus.dreq = d; bus.dwe = we; bus.iaddr = ia; bus.daddr = da;
    bus.mem_ack   = ack;
    bus.mem_rdata = m_busy ? rd_word(exp_addr()) : $urandom;
    bus.dwdata    = (m_busy && m_owner_d && m_we) ? wb_word(exp_addr()) : $urandom;
    exp_wd        = (m_busy && m_owner_d && m_we) ? wb_word(exp_addr()) : 32'd0;
    #1;
    chk1("mem_req", bus.mem_req, m_busy);
    chk1("igrant", bus.igrant, m_busy && !m_owner_d);
    chk1("dgrant", bus.dgrant, m_busy && m_owner_d);
    chk("mem_addr", bus.mem_addr, m_busy ? exp_addr() : 32'd0);
    chk1("mem_we", bus.mem_we, m_busy && m_owner_d && m_we);
    chk("mem_wdata", bus.mem_wdata, exp_wd);
    chk1("idone", bus.idone, m_done && !m_owner_d);
    chk1("ddone", bus.ddone, m_done && m_owner_d);
    chk1("ivalid", bus.ivalid, m_iv);
    chk1("dvalid", bus.dvalid, m_dv);
    if (m_busy) chk("widx", 32'(bus.widx), 32'(m_words));
    if (m_iv) chk("idata", bus.idata, m_idata);
    if (m_dv) chk("drdata", bus.drdata, m_drdata);
    seen_iv += int'(bus.ivalid);
    seen_dv += int'(bus.dvalid);
    seen_id += int'(bus.idone);
    seen_dd += int'(bus.ddone);

    nv_i = m_busy && ack && !m_owner_d;
    nv_d = m_busy && ack && m_owner_d && !m_we;
    nd   = bus.mem_rdata;
    if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (ack) begin
        m_words++;
        if (m_words == LW) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (i || d) begin
      m_owner_d = (i && d) ? !m_last_d : d;
      m_last_d  = m_owner_d;
      m_base    = m_owner_d ? da : ia;
      m_we      = m_owner_d && we;
      m_words   = 0;
      m_busy    = 1;
    end
    m_iv = nv_i;
    m_dv = nv_d;
    if (nv_i) m_idata = nd;
    if (nv_d) m_drdata = nd;
  endtask

  initial begin
    bit          i_want, d_want, d_we, ack;
    logic [31:0] i_a, d_a;
    int          base_iv, base_dv, base_id, base_dd;

    drive_idle();
    model_reset();
    seen_iv = 0; seen_dv = 0; seen_id = 0; seen_dd = 0;
    #1;
    check_all_zero("por");
    repeat (2) @(negedge clk);
    reset = 0;

    // Tie after reset -> D fill at 0x200; second tie -> I fill at 0x100; stray acks idle.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0};
    tbl[1]  = '{1, 1, 1, 1, 0, 1, 32'h200, 0, 0, 0, 0, 32'h0};
    tbl[2]  = '{1, 1, 1, 1, 0, 1, 32'h204, 0, 1, 0, 0, rd_word(32'h200)};
    tbl[3]  = '{1, 1, 1, 1, 0, 1, 32'h208, 0, 1, 0, 0, rd_word(32'h204)};
    tbl[4]  = '{1, 1, 1, 1, 0, 1, 32'h20C, 0, 1, 0, 0, rd_word(32'h208)};
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 32'h0,   0, 1, 0, 1, rd_word(32'h20C)};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0};
    tbl[7]  = '{1, 0, 1, 1, 1, 0, 32'h100, 0, 0, 0, 0, 32'h0};
    tbl[8]  = '{1, 0, 1, 1, 1, 0, 32'h104, 1, 0, 0, 0, rd_word(32'h100)};
    tbl[9]  = '{1, 0, 1, 1, 1, 0, 32'h108, 1, 0, 0, 0, rd_word(32'h104)};
    tbl[10] = '{1, 0, 1, 1, 1, 0, 32'h10C, 1, 0, 0, 0, rd_word(32'h108)};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 0, rd_word(32'h10C)};
    tbl[12] = '{0, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0};
    tbl[13] = '{0, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0};

    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      bus.ireq = tbl[k].i; bus.dreq = tbl[k].d; bus.dwe = 0;
      bus.iaddr = 32'h100; bus.daddr = 32'h200;
      bus.mem_ack = tbl[k].ack;
      bus.mem_rdata = tbl[k].e_req ? rd_word(tbl[k].e_addr) : 32'hDEAD_BEEF;
      #1;
      chk1($sformatf("t%0d_mem_req", k), bus.mem_req, tbl[k].e_req);
      chk1($sformatf("t%0d_igrant", k), bus.igrant, tbl[k].e_ig);
      chk1($sformatf("t%0d_dgrant", k), bus.dgrant, tbl[k].e_dg);
      chk($sformatf("t%0d_mem_addr", k), bus.mem_addr, tbl[k].e_addr);
      chk1($sformatf("t%0d_ivalid", k), bus.ivalid, tbl[k].e_iv);
      chk1($sformatf("t%0d_dvalid", k), bus.dvalid, tbl[k].e_dv);
      chk1($sformatf("t%0d_idone", k), bus.idone, tbl[k].e_id);
      chk1($sformatf("t%0d_ddone", k), bus.ddone, tbl[k].e_dd);
      if (tbl[k].e_iv) chk($sformatf("t%0d_idata", k), bus.idata, tbl[k].e_data);
      if (tbl[k].e_dv) chk($sformatf("t%0d_drdata", k), bus.drdata, tbl[k].e_data);
    end

    // Writeback at 0x200 with 3-cycle ack gaps: no dvalid, exactly one ddone.
    do_reset("rst1");
    base_dv = seen_dv; base_dd = seen_dd;
    run_cycle(0, 1, 1, 0, 32'h0, 32'h200);
    for (int w = 0; w < LW; w++) begin
      repeat (3) run_cycle(0, 1, 1, 0, 32'h0, 32'h200);
      run_cycle(0, 1, 1, 1, 32'h0, 32'h200);
    end
    run_cycle(0, 0, 0, 0, 32'h0, 32'h0);
    run_cycle(0, 0, 0, 0, 32'h0, 32'h0);
    chk("wb_dvalid_count", 32'(seen_dv - base_dv), 32'd0);
    chk("wb_ddone_count", 32'(seen_dd - base_dd), 32'd1);

    // Stray acks in idle, then I fill with gaps and ireq dropped after the 2nd ack.
    base_iv = seen_iv; base_id = seen_id;
    repeat (3) run_cycle(0, 0, 0, 1, 32'h0, 32'h0);
    run_cycle(1, 0, 0, 0, 32'h340, 32'h0);
    run_cycle(1, 0, 0, 1, 32'h340, 32'h0);
    repeat (3) run_cycle(1, 0, 0, 0, 32'h340, 32'h0);
    run_cycle(1, 0, 0, 1, 32'h340, 32'h0);
    for (int w = 2; w < LW; w++) begin
      repeat (3) run_cycle(0, 0, 0, 0, 32'h0, 32'h0);
      run_cycle(0, 0, 0, 1, 32'h0, 32'h0);
    end
    run_cycle(0, 0, 0, 1, 32'h0, 32'h0);
    run_cycle(0, 0, 0, 1, 32'h0, 32'h0);
    chk("drop_ivalid_count", 32'(seen_iv - base_iv), 32'(LW));
    chk("drop_idone_count", 32'(seen_id - base_id), 32'd1);

    // Reset in the middle of a D writeback at cnt=2, then a fresh burst from word 0.
    run_cycle(0, 1, 1, 0, 32'h0, 32'h300);
    run_cycle(0, 1, 1, 1, 32'h0, 32'h300);
    run_cycle(0, 1, 1, 1, 32'h0, 32'h300);
    @(negedge clk);
    reset = 1;
    #1;
    chk1("midrst_mem_req", bus.mem_req, 1'b0);
    chk1("midrst_dgrant", bus.dgrant, 1'b0);
    chk1("midrst_mem_we", bus.mem_we, 1'b0);
    chk("midrst_widx", 32'(bus.widx), 32'd0);
    drive_idle();
    model_reset();
    @(negedge clk);
    reset = 0;
    run_cycle(0, 1, 0, 0, 32'h0, 32'h400);
    run_cycle(0, 1, 0, 0, 32'h0, 32'h400);
    chk("restart_addr", bus.mem_addr, 32'h400);
    chk("restart_widx", 32'(bus.widx), 32'd0);
    repeat (LW + 2) run_cycle(0, 0, 0, 1, 32'h0, 32'h0);

    // Random traffic from two independent caches and a jittery memory.
    i_want = 0; d_want = 0; d_we = 0; i_a = '0; d_a = '0;
    for (int c = 0; c < 3000; c++) begin
      if (m_done) begin
        if (m_owner_d) d_want = 0;
        else i_want = 0;
      end
      if (m_busy && !m_owner_d && i_want && $urandom_range(0, 15) == 0) i_want = 0;
      if (m_busy && m_owner_d && d_want && $urandom_range(0, 15) == 0) d_want = 0;
      if (!i_want && $urandom_range(0, 3) == 0) begin
        i_want = 1;
        i_a = rand_line();
      end
      if (!d_want && $urandom_range(0, 3) == 0) begin
        d_want = 1;
        d_a = rand_line();
        d_we = bit'($urandom_range(0, 1));
      end
      ack = ($urandom_range(0, 2) != 0);
      run_cycle(i_want, d_want, d_we, ack, i_a, d_a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4: words per burst (power of two, >=2).
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port ireq, input, 1: I-cache line-fill request, held high until idone.
REQ-005 SHALL have port iaddr, input, 32: I-cache line base address (byte, line-aligned).
REQ-006 SHALL have ports igrant / ivalid / idone, outputs, 1 each: I burst active / read word valid / burst complete pulse.
REQ-007 SHALL have port idata, output, 32: I-cache read word.
REQ-008 SHALL have ports dreq / dwe, inputs, 1 each: D-cache request, held until ddone / 1 = line writeback, 0 = fill.
REQ-009 SHALL have ports daddr / dwdata, inputs, 32 each: D line base address / writeback word selected by widx.
REQ-010 SHALL have ports dgrant / dvalid / ddone, outputs, 1 each, and drdata, output, 32: D-side equivalents of the I-side outputs.
REQ-011 SHALL have port widx, output, log2(LINE_WORDS): current word index within the burst.
REQ-012 SHALL have ports mem_req / mem_we, outputs, 1 each, and mem_addr / mem_wdata, outputs, 32 each: main-memory command.
REQ-013 SHALL have ports mem_ack, input, 1 (one pulse per word transferred), and mem_rdata, input, 32 (valid with mem_ack).

Function
REQ-014 SHALL implement FSM IDLE -> I_BURST | D_BURST -> DONE -> IDLE.
REQ-015 IDLE: ireq only -> I_BURST; dreq only -> D_BURST; both -> side not served last (round-robin); neither -> stay.
REQ-016 Grant edge SHALL latch the base address, dwe (D side only) and owner, and clear word counter cnt.
REQ-017 In a BURST state: mem_req=1, owner grant=1, mem_addr=base+4*cnt, widx=cnt, mem_we=latched dwe (always 0 for I).
REQ-018 D writeback: mem_wdata=dwdata combinationally, cnt selects the word; otherwise mem_wdata=0.
REQ-019 Each mem_ack in a BURST state SHALL increment cnt; for reads, mem_rdata is registered to idata/drdata, with ivalid/dvalid pulsed one cycle later.
REQ-020 The mem_ack with cnt=LINE_WORDS-1 SHALL move the FSM to DONE; DONE lasts exactly one cycle, asserts idone/ddone for the owner, and returns to IDLE.
REQ-021 In DONE, the final read word's valid pulse SHALL coincide with done; all requests SHALL be ignored.
REQ-022 A request deasserted mid-burst SHALL NOT abort the burst; the burst SHALL complete normally.
REQ-023 mem_ack outside a BURST state SHALL be ignored; addresses SHALL wrap modulo 2^32.
REQ-024 Latency: request high in IDLE at cycle N -> mem_req high at N+1; done one cycle after the last ack.
REQ-025 Outputs not owned by the current burst (grant, valid, done, mem_*) SHALL be 0.

Reset
REQ-026 Reset SHALL immediately force IDLE, cnt=0, last-served=I (D wins the first tie), and every output to 0, including mid-burst.

Structure
REQ-027 FSM state encodings and LINE_WORDS default SHALL live in a shared package/include file with the other processor constants.
REQ-028 An optional sub-module rr_arbiter2 (2-way round-robin pick with last-served register) is natural; everything else is flat.

Verification
REQ-029 ireq=1, iaddr=0x100, memory acks every cycle -> mem_addr 0x100, 0x104, 0x108, 0x10C; four ivalid pulses; idone 1 cycle after 4th ack.
REQ-030 ireq and dreq rise together after reset -> D served first; the second tie -> I served.
REQ-031 dreq=1, dwe=1, daddr=0x200 -> mem_we=1; mem_wdata follows dwdata for widx 0..3; no dvalid pulses; ddone after 4th ack.
REQ-032 ireq dropped at 2nd ack of I burst -> remaining 2 words transferred; idone still pulses.
REQ-033 reset asserted mid-D-burst at cnt=2 -> mem_req and dgrant drop in the same cycle; the next request restarts at cnt=0.
REQ-034 Stray mem_ack in IDLE, and ack gaps of 3 cycles -> no state change in IDLE; correct addresses and no extra valid pulses during the burst.
